// File: rtl/led_show_sched.sv
// ---------------------------------------------------------------------------
// led_show_sched
//
// Sequencer for an LED light show. It steps through four LED effects. Each
// effect plays through four Breath periods (io_period 0..3), and a dark gap
// of BLANK_TICKS cycles separates one effect from the next. A push-button
// (io_next) skips ahead, io_hold freezes the show, and io_enable=0 parks the
// show in IDLE.
//
// Build option:
//   SHOW_AUTO_EN defined   : a dwell timer advances io_period every
//                            DWELL_TICKS cycles, and io_next skips straight
//                            to the next effect.
//   SHOW_AUTO_EN undefined : there is no dwell timer. Each io_next press
//                            advances io_period, and a press at period 3
//                            moves on to the next effect.
//
// Parameters:
//   DWELL_TICKS  clock cycles per period step (2..2^20)
//   BLANK_TICKS  clock cycles of dark gap between effects (2..2^20)
//
// Ports:
//   clock        system clock (100 kHz nominal)
//   reset        asynchronous active-low reset
//   io_enable    1 = show runs, 0 = show forced idle
//   io_hold      1 = freeze timer, period and effect
//   io_next      raw asynchronous push-button, active-high
//   io_fx0..3    LED patterns from the effect blocks (io_fx0 = Breath)
//   io_period    period select driven to the Breath block
//   io_sel       active effect index
//   io_leds      registered LED drive
//   io_step      one-cycle pulse on every period or effect change
// ---------------------------------------------------------------------------
module led_show_sched #(
  parameter int DWELL_TICKS = 400000,
  parameter int BLANK_TICKS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_enable,
  input  logic       io_hold,
  input  logic       io_next,
  input  logic [7:0] io_fx0,
  input  logic [7:0] io_fx1,
  input  logic [7:0] io_fx2,
  input  logic [7:0] io_fx3,
  output logic [1:0] io_period,
  output logic [1:0] io_sel,
  output logic [7:0] io_leds,
  output logic       io_step
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam int BLANK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_TICKS - 1);

`ifdef SHOW_AUTO_EN
  localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

  logic [DWELL_W-1:0] dwell_cnt_r;
`endif

  state_t             state_r;
  logic [BLANK_W-1:0] blank_cnt_r;
  logic [1:0]         period_r;
  logic [1:0]         sel_r;
  logic [7:0]         leds_r;
  logic               step_r;

  // The button synchronizer and the edge-detect history.
  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  logic       next_ev_s;
  logic [7:0] fx_sel_s;

  // Rising edge of the synchronized button. A long press makes one event.
  assign next_ev_s = sync2_r & ~prev_r;

  // Select the pattern of the active effect.
  always_comb begin
    fx_sel_s = 8'h00;
    case (sel_r)
      2'd0:    fx_sel_s = io_fx0;
      2'd1:    fx_sel_s = io_fx1;
      2'd2:    fx_sel_s = io_fx2;
      2'd3:    fx_sel_s = io_fx3;
      default: fx_sel_s = 8'h00;
    endcase
  end

  // Show FSM: the synchronizer, the counters and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      blank_cnt_r <= '0;
      period_r    <= 2'd0;
      sel_r       <= 2'd0;
      leds_r      <= 8'h00;
      step_r      <= 1'b0;
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      prev_r      <= 1'b0;
`ifdef SHOW_AUTO_EN
      dwell_cnt_r <= '0;
`endif
    end else begin
      sync1_r <= io_next;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      step_r  <= 1'b0;

      // The LEDs follow the state of the previous cycle, so they trail
      // state and io_sel by one clock.
      if ((state_r == RUN) || (state_r == HOLD)) begin
        leds_r <= fx_sel_s;
      end else begin
        leds_r <= 8'h00;
      end

      if (!io_enable) begin
        state_r     <= IDLE;
        blank_cnt_r <= '0;
        period_r    <= 2'd0;
        sel_r       <= 2'd0;
`ifdef SHOW_AUTO_EN
        dwell_cnt_r <= '0;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            state_r     <= RUN;
            blank_cnt_r <= '0;
            period_r    <= 2'd0;
            sel_r       <= 2'd0;
`ifdef SHOW_AUTO_EN
            dwell_cnt_r <= '0;
`endif
          end

          RUN: begin
            if (io_hold) begin
              state_r <= HOLD;
            end else if (next_ev_s) begin
`ifdef SHOW_AUTO_EN
              state_r     <= BLANK;
              blank_cnt_r <= '0;
              dwell_cnt_r <= '0;
`else
              if (period_r == 2'd3) begin
                state_r     <= BLANK;
                blank_cnt_r <= '0;
              end else begin
                period_r <= period_r + 2'd1;
                step_r   <= 1'b1;
              end
`endif
            end
`ifdef SHOW_AUTO_EN
            else if (dwell_cnt_r == DWELL_LAST) begin
              dwell_cnt_r <= '0;
              if (period_r == 2'd3) begin
                state_r     <= BLANK;
                blank_cnt_r <= '0;
              end else begin
                period_r <= period_r + 2'd1;
                step_r   <= 1'b1;
              end
            end else begin
              dwell_cnt_r <= dwell_cnt_r + 1'b1;
            end
`endif
          end

          // Everything stays frozen. Button events are dropped.
          HOLD: begin
            if (!io_hold) begin
              state_r <= RUN;
            end
          end

          // The dark gap between effects. Button events are dropped.
          BLANK: begin
            if (blank_cnt_r == BLANK_LAST) begin
              state_r     <= RUN;
              blank_cnt_r <= '0;
              sel_r       <= sel_r + 2'd1;
              period_r    <= 2'd0;
              step_r      <= 1'b1;
`ifdef SHOW_AUTO_EN
              dwell_cnt_r <= '0;
`endif
            end else begin
              blank_cnt_r <= blank_cnt_r + 1'b1;
            end
          end

          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign io_period = period_r;
  assign io_sel    = sel_r;
  assign io_leds   = leds_r;
  assign io_step   = step_r;

endmodule

// File: tb/tb_led_show_sched.sv
// ---------------------------------------------------------------------------
// tb_led_show_sched
//
// Directed bench for led_show_sched with DWELL_TICKS=8 and BLANK_TICKS=4.
// Every expected value is worked out by hand. The comments give the number
// of the clock edge being checked, counted from the first edge after reset
// is released (E1). Outputs are sampled 1 ns after the rising edge.
// The run follows the SHOW_AUTO_EN build option of the design.
// ---------------------------------------------------------------------------
module tb_led_show_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_enable;
  logic       io_hold;
  logic       io_next;
  logic [7:0] io_fx0;
  logic [7:0] io_fx1;
  logic [7:0] io_fx2;
  logic [7:0] io_fx3;
  logic [1:0] io_period;
  logic [1:0] io_sel;
  logic [7:0] io_leds;
  logic       io_step;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  led_show_sched #(
    .DWELL_TICKS(8),
    .BLANK_TICKS(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_enable (io_enable),
    .io_hold   (io_hold),
    .io_next   (io_next),
    .io_fx0    (io_fx0),
    .io_fx1    (io_fx1),
    .io_fx2    (io_fx2),
    .io_fx3    (io_fx3),
    .io_period (io_period),
    .io_sel    (io_sel),
    .io_leds   (io_leds),
    .io_step   (io_step)
  );

  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One button press. The pulse is sampled on the first edge and takes
  // effect two edges later. The task returns just after that edge.
  task automatic press_wait();
    io_next = 1'b1;
    tick(1);
    io_next = 1'b0;
    tick(2);
  endtask

  task automatic press_n(input int n);
    for (int i = 0; i < n; i++) press_wait();
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_period"}, {6'd0, io_period}, 8'h00);
    check_vec({tag, "_sel"},    {6'd0, io_sel},    8'h00);
    check_vec({tag, "_leds"},   io_leds,           8'h00);
    check_vec({tag, "_step"},   {7'd0, io_step},   8'h00);
  endtask

  initial begin
    reset     = 1'b1;
    io_enable = 1'b1;
    io_hold   = 1'b0;
    io_next   = 1'b0;
    io_fx0    = 8'hA5;
    io_fx1    = 8'h3C;
    io_fx2    = 8'h0F;
    io_fx3    = 8'hF0;

    // Reset clears the outputs at once, without waiting for a clock edge.
    #1 reset = 1'b0;
    #2 check_all_zero("rst_async");
    tick(1);
    check_all_zero("rst_held");
    reset = 1'b1;

    tick(1);                                  // E1: IDLE -> RUN
    check_all_zero("run_entry");
    tick(1);                                  // E2: LEDs show fx0
    check_vec("run_leds", io_leds, 8'hA5);
    check_vec("run_period", {6'd0, io_period}, 8'h00);

`ifdef SHOW_AUTO_EN
    // Free run: the period steps every 8 cycles.
    tick(6);                                  // E8
    check_vec("dw_p0", {6'd0, io_period}, 8'h00);
    check_vec("dw_s0", {7'd0, io_step}, 8'h00);
    tick(1);                                  // E9
    check_vec("dw_p1", {6'd0, io_period}, 8'h01);
    check_vec("dw_s1", {7'd0, io_step}, 8'h01);
    tick(1);                                  // E10
    check_vec("dw_s1_end", {7'd0, io_step}, 8'h00);
    tick(7);                                  // E17
    check_vec("dw_p2", {6'd0, io_period}, 8'h02);
    check_vec("dw_s2", {7'd0, io_step}, 8'h01);
    tick(8);                                  // E25
    check_vec("dw_p3", {6'd0, io_period}, 8'h03);
    check_vec("dw_s3", {7'd0, io_step}, 8'h01);
    tick(8);                                  // E33: BLANK entry, no step
    check_vec("bl_entry_step", {7'd0, io_step}, 8'h00);
    check_vec("bl_entry_leds", io_leds, 8'hA5);
    tick(1);                                  // E34
    check_vec("bl_dark", io_leds, 8'h00);
    tick(3);                                  // E37: RUN with effect 1
    check_vec("bl_exit_sel", {6'd0, io_sel}, 8'h01);
    check_vec("bl_exit_period", {6'd0, io_period}, 8'h00);
    check_vec("bl_exit_step", {7'd0, io_step}, 8'h01);
    check_vec("bl_exit_leds", io_leds, 8'h00);
    tick(1);                                  // E38
    check_vec("fx1_leds", io_leds, 8'h3C);

    // Hold at dwell count 5. A press during the hold is dropped.
    tick(4);                                  // E42: dwell count = 5
    io_hold = 1'b1;
    tick(5);
    press_wait();                             // E50
    check_vec("hold_sel", {6'd0, io_sel}, 8'h01);
    check_vec("hold_period", {6'd0, io_period}, 8'h00);
    tick(12);                                 // E62
    check_vec("hold_period_end", {6'd0, io_period}, 8'h00);
    check_vec("hold_leds", io_leds, 8'h3C);
    io_hold = 1'b0;
    // Counts 5, 6 and 7 are left, so the step comes on the fourth edge.
    tick(3);                                  // E65
    check_vec("resume_no_step", {7'd0, io_step}, 8'h00);
    tick(1);                                  // E66
    check_vec("resume_period", {6'd0, io_period}, 8'h01);
    check_vec("resume_step", {7'd0, io_step}, 8'h01);

    // Presses skip to the next effect, through the dark gap.
    press_wait();                             // E69
    tick(4);                                  // E73
    check_vec("skip_sel2", {6'd0, io_sel}, 8'h02);
    press_wait();                             // E76
    tick(4);                                  // E80
    check_vec("skip_sel3", {6'd0, io_sel}, 8'h03);
    check_vec("skip_step", {7'd0, io_step}, 8'h01);

    // Press at effect 3: the button is sampled at E81 and acts at E83.
    io_next = 1'b1;
    tick(1);                                  // E81
    io_next = 1'b0;
    tick(1);                                  // E82
    check_vec("k1_sel", {6'd0, io_sel}, 8'h03);
    tick(1);                                  // E83: still RUN before this edge
    check_vec("k2_leds", io_leds, 8'hF0);
    tick(1);                                  // E84: BLANK since E83
    check_vec("k3_leds", io_leds, 8'h00);
    tick(2);                                  // E86
    check_vec("wrap_pre", {6'd0, io_sel}, 8'h03);
    tick(1);                                  // E87
    check_vec("wrap_sel", {6'd0, io_sel}, 8'h00);
    check_vec("wrap_step", {7'd0, io_step}, 8'h01);

    // Holding the button down for 20 cycles advances the effect only once.
    io_next = 1'b1;
    tick(20);                                 // E107
    check_vec("long_sel", {6'd0, io_sel}, 8'h01);
    io_next = 1'b0;
    tick(5);                                  // E112
    check_vec("long_sel_after", {6'd0, io_sel}, 8'h01);

    // Dropping io_enable during BLANK gives IDLE on the next edge.
    press_wait();                             // E115: BLANK
    tick(1);
    io_enable = 1'b0;
    tick(1);                                  // E117
    check_all_zero("en_drop");
    io_enable = 1'b1;
    tick(1);                                  // E118: RUN again
    check_vec("en_back_leds0", io_leds, 8'h00);
    tick(1);                                  // E119
    check_vec("en_back_leds", io_leds, 8'hA5);
    check_vec("en_back_sel", {6'd0, io_sel}, 8'h00);

    // Reset in the middle of RUN.
    tick(8);                                  // E127: period 1 since E126
    check_vec("pre_rst_period", {6'd0, io_period}, 8'h01);
`else
    // Without the dwell timer the period moves only on a button press.
    tick(100);
    check_vec("idle_period", {6'd0, io_period}, 8'h00);
    check_vec("idle_step", {7'd0, io_step}, 8'h00);
    check_vec("idle_leds", io_leds, 8'hA5);
    press_wait();
    check_vec("man_p1", {6'd0, io_period}, 8'h01);
    check_vec("man_s1", {7'd0, io_step}, 8'h01);
    tick(1);
    check_vec("man_s1_end", {7'd0, io_step}, 8'h00);
    press_wait();
    check_vec("man_p2", {6'd0, io_period}, 8'h02);
    press_wait();
    check_vec("man_p3", {6'd0, io_period}, 8'h03);
    check_vec("man_s3", {7'd0, io_step}, 8'h01);
    press_wait();                             // press at period 3 -> BLANK
    check_vec("man_bl_period", {6'd0, io_period}, 8'h03);
    check_vec("man_bl_step", {7'd0, io_step}, 8'h00);
    tick(1);
    check_vec("man_bl_dark", io_leds, 8'h00);
    tick(3);
    check_vec("man_bl_sel", {6'd0, io_sel}, 8'h01);
    check_vec("man_bl_p0", {6'd0, io_period}, 8'h00);
    check_vec("man_bl_exit_step", {7'd0, io_step}, 8'h01);
    tick(1);
    check_vec("man_fx1", io_leds, 8'h3C);

    // A press during HOLD is dropped.
    io_hold = 1'b1;
    tick(1);
    press_wait();
    check_vec("man_hold_period", {6'd0, io_period}, 8'h00);
    check_vec("man_hold_leds", io_leds, 8'h3C);
    io_hold = 1'b0;
    tick(1);

    // A button held down for 50 cycles counts as one press.
    io_next = 1'b1;
    tick(50);
    check_vec("man_long_period", {6'd0, io_period}, 8'h01);
    check_vec("man_long_sel", {6'd0, io_sel}, 8'h01);
    io_next = 1'b0;
    tick(3);

    // Step through effects 2 and 3, then wrap back to effect 0.
    press_n(3);
    tick(4);
    check_vec("man_sel2", {6'd0, io_sel}, 8'h02);
    check_vec("man_sel2_p", {6'd0, io_period}, 8'h00);
    press_n(4);
    tick(4);
    check_vec("man_sel3", {6'd0, io_sel}, 8'h03);
    tick(1);
    check_vec("man_fx3", io_leds, 8'hF0);
    press_n(4);
    tick(3);
    check_vec("man_wrap_pre", {6'd0, io_sel}, 8'h03);
    tick(1);
    check_vec("man_wrap_sel", {6'd0, io_sel}, 8'h00);
    check_vec("man_wrap_step", {7'd0, io_step}, 8'h01);

    // Dropping io_enable during BLANK.
    press_n(4);
    tick(1);
    io_enable = 1'b0;
    tick(1);
    check_all_zero("man_en_drop");
    io_enable = 1'b1;
    tick(2);
    check_vec("man_en_back_leds", io_leds, 8'hA5);

    // Reset in the middle of RUN.
    press_wait();
    check_vec("man_pre_rst_period", {6'd0, io_period}, 8'h01);
`endif

    reset = 1'b0;
    #1 check_all_zero("rst_mid_run");
    #2 reset = 1'b1;
    tick(1);                                  // IDLE -> RUN
    check_vec("restart_leds0", io_leds, 8'h00);
    tick(1);
    check_vec("restart_leds", io_leds, 8'hA5);
    check_vec("restart_period", {6'd0, io_period}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/led_show_sched.md
LED_SHOW_SCHED -- requirements
Module: led_show_sched

Interface
REQ-001 SHALL have parameter DWELL_TICKS, default 400000, meaning clock cycles per period step (4 s at 100 kHz); legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_TICKS, default 50000, meaning clock cycles of dark gap between effects; legal range 2..2^20.
REQ-003 SHALL have port clock  input  1  system clock, 100 kHz nominal.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_enable  input  1  1 = show runs; 0 = show forced idle.
REQ-006 SHALL have port io_hold  input  1  1 = freeze dwell timer and effect.
REQ-007 SHALL have port io_next  input  1  raw asynchronous push-button, active-high.
REQ-008 SHALL have ports io_fx0..io_fx3  input  8 each  LED patterns from effect blocks (io_fx0 = Breath output).
REQ-009 SHALL have port io_period  output  2  period select driven to Breath io_period.
REQ-010 SHALL have port io_sel  output  2  active effect index.
REQ-011 SHALL have port io_leds  output  8  LED drive.
REQ-012 SHALL have port io_step  output  1  one-cycle pulse on every period or effect change.

Function
REQ-013 SHALL implement states IDLE, RUN, HOLD, BLANK.
REQ-014 SHALL pass io_next through a 2-flop synchronizer plus edge-detect flop; a rising edge sampled at clock edge k SHALL act at clock edge k+2; a level held high SHALL count as one event.
REQ-015 Transition priority per cycle SHALL be: io_enable=0 > io_hold > next-event > dwell terminal count.
REQ-016 io_enable=0 SHALL force IDLE next edge from any state, clearing counters, io_sel=0, io_period=0.
REQ-017 IDLE SHALL go to RUN on the first edge with io_enable=1, dwell counter 0.
REQ-018 RUN: dwell counter SHALL count 0..DWELL_TICKS-1; at terminal count it SHALL clear and io_period SHALL increment; if io_period was 3 it SHALL instead enter BLANK.
REQ-019 RUN with io_hold=1 SHALL enter HOLD; HOLD SHALL freeze dwell counter, io_period, io_sel; HOLD with io_hold=0 SHALL return to RUN resuming the frozen count.
REQ-020 Next-event in RUN SHALL enter BLANK, clearing dwell counter; next-events in HOLD, BLANK, IDLE SHALL be discarded.
REQ-021 BLANK SHALL last exactly BLANK_TICKS cycles, then set io_sel = (io_sel+1) mod 4 (3 wraps to 0), io_period=0, enter RUN.
REQ-022 io_leds SHALL be registered: io_fx[io_sel] in RUN/HOLD, 8'h00 in IDLE/BLANK, one cycle after the state/io_sel it reflects.
REQ-023 io_step SHALL pulse for one cycle coincident with each io_period increment and each io_sel change; never in IDLE entry.
REQ-024 Counter widths SHALL be ceil(log2(max tick)) bits; no overflow for legal parameters.

Reset
REQ-025 Reset low SHALL immediately force: state IDLE, io_period=0, io_sel=0, io_leds=8'h00, io_step=0, counters 0, synchronizer flops 0.
REQ-026 Reset asserted mid-RUN or mid-BLANK SHALL abandon the operation; after release operation SHALL restart per REQ-017.

Configuration
REQ-027 Macro SHOW_AUTO_EN defined SHALL include the dwell timer; behaviour per REQ-018.
REQ-028 SHOW_AUTO_EN undefined SHALL omit the dwell counter; in RUN each next-event SHALL increment io_period, and a next-event at io_period=3 SHALL enter BLANK; all else unchanged.

Verification (DWELL_TICKS=8, BLANK_TICKS=4, SHOW_AUTO_EN defined unless stated)
REQ-029 Reset low, then release with io_enable=1, io_fx0=8'hA5 -> RUN next edge, io_leds=8'hA5 one cycle later, io_period=0.
REQ-030 Free run 32 cycles in RUN -> io_period steps 0,1,2,3 every 8 cycles with io_step pulses, then io_leds=00 for 4 cycles, io_sel=1, io_period=0.
REQ-031 io_hold=1 for 20 cycles at dwell count 5 -> no change in io_period/io_sel; after release next step after exactly 3 more cycles.
REQ-032 io_next pulse at io_sel=3 in RUN -> BLANK at edge k+2, io_sel=0 after 4 blank cycles; io_next held high 50 cycles -> single advance.
REQ-033 io_enable dropped during BLANK -> IDLE next edge, io_leds=00, io_sel=0; reset pulsed mid-RUN -> all outputs 0 asynchronously.
REQ-034 SHOW_AUTO_EN undefined, 100 idle cycles -> io_period stays 0; four io_next pulses -> io_period 1,2,3 then BLANK, io_sel=1.
